// File: rtl/space_invaders_pkg.sv
// Shared constants for the space-invaders display path: screen limits, colours,
// the alien sprite bitmap and the alien drawer state encoding.
// Ports: none (package).
package space_invaders_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  localparam logic [2:0] COLOUR_ALIEN = 3'b010;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // Element 0 is the top row; within a row bit 7 is the leftmost column.
  localparam logic [0:7][7:0] SPRITE_ALIEN = {
    8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } drawer_state_t;

  // Sprite bit at (row, col), col 0 being the leftmost pixel.
  function automatic logic sprite_pixel(input logic [2:0] row, input logic [2:0] col);
    return SPRITE_ALIEN[row][3'd7 - col];
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster counter over a sprite box: col is the inner index, row the outer one.
// Ports: clk/reset_n (sync, active-low), clear (priority), enable (advance),
//        col/row (current position), last (high on the final box position).
module sprite_scan_counter
  import space_invaders_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic       last
);

  localparam logic [2:0] COL_MAX = 3'(COLS - 1);
  localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  // Advancing from the last position wraps both indices to zero, so the next
  // scan phase starts from the top-left corner without an explicit clear.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      col <= 3'd0;
      row <= 3'd0;
    end else if (enable) begin
      if (col == COL_MAX) begin
        col <= 3'd0;
        row <= (row == ROW_MAX) ? 3'd0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/alien_drawer.sv
// Redraws one alien: erases the previous 8x8 box, then plots the sprite at the
// new position, one pixel per clock onto the 160x120 VGA plot bus.
// Ports: update/x_pos/y_pos/alive (request, sampled only when idle),
//        vga_x/vga_y/vga_colour/vga_plot (registered pixel), busy, done (pulse).
module alien_drawer
  import space_invaders_pkg::*;
#(
  parameter int         SPRITE_W  = 8,
  parameter int         SPRITE_H  = 8,
  parameter logic [2:0] FG_COLOUR = COLOUR_ALIEN,
  parameter logic [2:0] BG_COLOUR = COLOUR_BLACK,
  parameter int         SCREEN_W  = SCREEN_WIDTH,
  parameter int         SCREEN_H  = SCREEN_HEIGHT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       update,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  input  logic       alive,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  drawer_state_t state, state_nxt;

  logic [7:0] new_x, old_x;
  logic [6:0] new_y, old_y;
  logic       new_alive, old_valid;

  logic       accept;
  logic       cnt_en;
  logic       cnt_last;
  logic [2:0] col, row;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       on_screen;
  logic       plot_nxt;
  logic [2:0] colour_nxt;

  assign accept = (state == ST_IDLE) && update;
  assign cnt_en = (state == ST_ERASE) || (state == ST_DRAW);

  sprite_scan_counter #(
    .COLS(SPRITE_W),
    .ROWS(SPRITE_H)
  ) u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (cnt_en),
    .col    (col),
    .row    (row),
    .last   (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (update)   state_nxt = old_valid ? ST_ERASE : ST_DRAW;
      ST_ERASE: if (cnt_last) state_nxt = ST_DRAW;
      ST_DRAW:  if (cnt_last) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Sums are widened by one bit so positions near the right/bottom edge clip
  // instead of wrapping back onto the left/top of the screen.
  always_comb begin
    base_x     = (state == ST_ERASE) ? old_x : new_x;
    base_y     = (state == ST_ERASE) ? old_y : new_y;
    sum_x      = {1'b0, base_x} + {6'd0, col};
    sum_y      = {1'b0, base_y} + {5'd0, row};
    on_screen  = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
    colour_nxt = (state == ST_DRAW) ? FG_COLOUR : BG_COLOUR;
    plot_nxt   = 1'b0;
    if (state == ST_ERASE)
      plot_nxt = on_screen;
    else if (state == ST_DRAW)
      plot_nxt = on_screen && new_alive && sprite_pixel(row, col);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      new_x      <= 8'd0;
      new_y      <= 7'd0;
      new_alive  <= 1'b0;
      old_x      <= 8'd0;
      old_y      <= 7'd0;
      old_valid  <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= BG_COLOUR;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        new_x     <= x_pos;
        new_y     <= y_pos;
        new_alive <= alive;
      end
      // A dead alien leaves old_valid low so its box is never erased again.
      if (state == ST_DONE) begin
        old_x     <= new_x;
        old_y     <= new_y;
        old_valid <= new_alive;
      end
      vga_x      <= sum_x[7:0];
      vga_y      <= sum_y[6:0];
      vga_colour <= colour_nxt;
      vga_plot   <= plot_nxt;
      done       <= (state == ST_DONE);
      // Outputs lag the state by one cycle; busy is aligned to them so it
      // stays high up to and including the done pulse.
      busy       <= (state_nxt != ST_IDLE) || (state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_alien_drawer.sv
module tb_alien_drawer;

  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       update = 1'b0;
  logic [7:0] x_pos = 8'd0;
  logic [6:0] y_pos = 7'd0;
  logic       alive = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  alien_drawer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .update    (update),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .alive     (alive),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0] sprite_rows [8] = '{8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5};

  // Expected outputs per cycle, indexed by the number of rising edges seen.
  bit exp_plot [MAXC];
  bit exp_busy [MAXC];
  bit exp_done [MAXC];
  int exp_x [MAXC];
  int exp_y [MAXC];
  int exp_c [MAXC];

  bit m_old_valid = 1'b0;
  int m_old_x = 0;
  int m_old_y = 0;
  int m_idle_from = 0;

  bit chk_en = 1'b0;
  int n_fg, n_bg, n_done, done_at, first_x, first_y, max_x, max_y;
  bit seen_first;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clr_stats();
    n_fg = 0; n_bg = 0; n_done = 0; done_at = -1;
    first_x = -1; first_y = -1; max_x = -1; max_y = -1;
    seen_first = 1'b0;
  endtask

  task automatic set_px(input int t, input int px, input int py, input int c);
    if (t < MAXC) begin
      exp_plot[t] = 1'b1; exp_x[t] = px; exp_y[t] = py; exp_c[t] = c;
    end
  endtask

  // Update driven during cycle d: pixel k of the operation is visible at d+2+k,
  // done arrives straight after the last pixel slot.
  task automatic model_accept(input int d, input int x, input int y, input bit a);
    int k;
    int px, py;
    logic [7:0] bits;
    k = 0;
    if (m_old_valid) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          px = m_old_x + c; py = m_old_y + r;
          if (px < 160 && py < 120) set_px(d + 2 + k, px, py, 0);
          k++;
        end
    end
    for (int r = 0; r < 8; r++) begin
      bits = sprite_rows[r];
      for (int c = 0; c < 8; c++) begin
        px = x + c; py = y + r;
        if (a && bits[7 - c] && px < 160 && py < 120) set_px(d + 2 + k, px, py, 2);
        k++;
      end
    end
    if (d + 2 + k < MAXC) exp_done[d + 2 + k] = 1'b1;
    for (int i = d + 1; i <= d + 2 + k && i < MAXC; i++) exp_busy[i] = 1'b1;
    m_idle_from = d + 2 + k;
    m_old_x = x; m_old_y = y; m_old_valid = a;
  endtask

  task automatic model_reset(input int r);
    for (int i = r + 1; i < MAXC; i++) begin
      exp_plot[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    end
    m_old_valid = 1'b0;
    m_idle_from = r + 1;
  endtask

  task automatic do_op(input int x, input int y, input bit a, output int d);
    @(posedge clk); #1;
    d = cyc;
    update = 1'b1; x_pos = 8'(x); y_pos = 7'(y); alive = a;
    if (d >= m_idle_from) model_accept(d, x, y, a);
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < m_idle_from + 2 && cyc < MAXC) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc >= MAXC) begin
        check("cycle_budget", cyc, MAXC - 1);
      end else begin
        check("plot", int'(vga_plot), int'(exp_plot[cyc]));
        check("busy", int'(busy), int'(exp_busy[cyc]));
        check("done", int'(done), int'(exp_done[cyc]));
        if (exp_plot[cyc] && vga_plot) begin
          check("vga_x", int'(vga_x), exp_x[cyc]);
          check("vga_y", int'(vga_y), exp_y[cyc]);
          check("colour", int'(vga_colour), exp_c[cyc]);
        end
      end
      if (vga_plot) begin
        if (vga_colour == 3'b010) begin
          n_fg++;
          if (int'(vga_x) > max_x) max_x = int'(vga_x);
          if (int'(vga_y) > max_y) max_y = int'(vga_y);
        end else begin
          n_bg++;
        end
        if (!seen_first) begin
          seen_first = 1'b1; first_x = int'(vga_x); first_y = int'(vga_y);
        end
      end
      if (done) begin
        n_done++; done_at = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    int d, dd, r;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // Fresh draw, nothing to erase.
    clr_stats();
    do_op(10, 20, 1'b1, d);
    wait_idle();
    check("op1_fg", n_fg, 36);
    check("op1_bg", n_bg, 0);
    check("op1_first_x", first_x, 13);
    check("op1_first_y", first_y, 20);
    check("op1_latency", done_at - d, 66);
    check("op1_ndone", n_done, 1);
    check("op1_max_x", max_x, 17);
    check("op1_max_y", max_y, 27);

    // Move right by two: full erase of the old box, then redraw.
    clr_stats();
    do_op(12, 20, 1'b1, d);
    wait_idle();
    check("op2_bg", n_bg, 64);
    check("op2_fg", n_fg, 36);
    check("op2_first_x", first_x, 10);
    check("op2_latency", done_at - d, 130);
    check("op2_max_x", max_x, 19);

    // Bottom-right corner: only the on-screen quarter is drawn.
    clr_stats();
    do_op(156, 116, 1'b1, d);
    wait_idle();
    check("op3_bg", n_bg, 64);
    check("op3_fg", n_fg, 9);
    check("op3_max_x", max_x, 159);
    check("op3_max_y", max_y, 119);
    check("op3_latency", done_at - d, 130);

    // Killed alien: clipped erase of the corner box, no draw.
    clr_stats();
    do_op(50, 50, 1'b0, d);
    wait_idle();
    check("op4_bg", n_bg, 16);
    check("op4_fg", n_fg, 0);
    check("op4_latency", done_at - d, 130);
    check("op4_ndone", n_done, 1);

    // No erase after death; extra update pulses while busy are dropped.
    clr_stats();
    do_op(40, 50, 1'b1, d);
    repeat (10) @(posedge clk);
    do_op(70, 70, 1'b1, dd);
    repeat (30) @(posedge clk);
    do_op(90, 10, 1'b0, dd);
    wait_idle();
    check("op5_bg", n_bg, 0);
    check("op5_fg", n_fg, 36);
    check("op5_latency", done_at - d, 66);
    check("op5_ndone", n_done, 1);

    // Reset while erasing.
    clr_stats();
    do_op(40, 60, 1'b1, d);
    repeat (20) @(posedge clk);
    #1;
    r = cyc;
    reset_n = 1'b0;
    model_reset(r);
    @(posedge clk); #1;
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ndone", n_done, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // After reset the next update draws without erasing.
    clr_stats();
    do_op(30, 30, 1'b1, d);
    wait_idle();
    check("op7_bg", n_bg, 0);
    check("op7_fg", n_fg, 36);
    check("op7_first_x", first_x, 33);
    check("op7_first_y", first_y, 30);
    check("op7_latency", done_at - d, 66);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
